masked_sbox_lookup_requester: RTL and testbench

Initiator side of the dual-port masked S-box table BRAMs, such as the x26/x49 stage tables. It accepts lookup requests (two 10-bit table addresses plus a tag) on a valid/ready handshake and drives ADDRA/ADDRB/EN of one table instance. It tracks the table's fixed two-cycle registered-read latency and returns DOA/DOB with the tag through an output FIFO. Credit-based issue guarantees the FIFO never overflows, so `out_ready` has no combinational path to `in_ready`.

---
 rtl/masked_lut_pkg.sv | 16 +
 rtl/lut_result_fifo.sv | 52 +++++
 rtl/masked_sbox_lookup_requester.sv | 96 +++++++++
 tb/tb_masked_sbox_lookup_requester.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_lut_pkg.sv
// Shared widths and the result record for masked S-box table requesters.
package masked_lut_pkg;

  localparam int unsigned LUT_ADDR_W    = 10;
  localparam int unsigned LUT_DATA_W    = 8;
  localparam int unsigned LUT_RD_LAT    = 2;
  localparam int unsigned LUT_TAG_MAX_W = 16;

  // Tag field is sized for the widest supported tag; narrower tags are zero-extended.
  typedef struct packed {
    logic [LUT_DATA_W-1:0]    doa;
    logic [LUT_DATA_W-1:0]    dob;
    logic [LUT_TAG_MAX_W-1:0] tag;
  } lut_result_t;

endpackage

// File: rtl/lut_result_fifo.sv
// Circular result FIFO; push and pop may coincide in any state, including full.
module lut_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/masked_sbox_lookup_requester.sv
// Issues lookups to a dual-port masked S-box BRAM and returns results in order
// through a credit-protected FIFO, so out_ready never reaches in_ready.
module masked_sbox_lookup_requester
  import masked_lut_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LUT_ADDR_W-1:0] in_addr_a,
  input  logic [LUT_ADDR_W-1:0] in_addr_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic [LUT_ADDR_W-1:0] ADDRA,
  output logic [LUT_ADDR_W-1:0] ADDRB,
  output logic                  EN,
  input  logic [LUT_DATA_W-1:0] DOA,
  input  logic [LUT_DATA_W-1:0] DOB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LUT_DATA_W-1:0] out_doa,
  output logic [LUT_DATA_W-1:0] out_dob,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int unsigned CRED_W = $clog2(DEPTH + 1);

  logic [CRED_W-1:0] cred;
  logic              v1;
  logic              v2;
  logic [TAG_W-1:0]  tag1;
  logic [TAG_W-1:0]  tag2;
  logic              acc;
  logic              pop;
  lut_result_t       wr_res;
  lut_result_t       head;
  logic              unused_tag_bits;

  assign in_ready = !rst && (cred != '0);
  assign acc      = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Same enable loads the address latch on accept and advances the output
  // register while a read sits in v1; other latch loads are harmless bubbles.
  assign EN    = acc | v1;
  assign ADDRA = in_addr_a;
  assign ADDRB = in_addr_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
      cred <= CRED_W'(DEPTH);
    end else begin
      v1   <= acc;
      tag1 <= in_tag;
      v2   <= v1;
      tag2 <= tag1;
      if (acc && !pop) begin
        cred <= cred - CRED_W'(1);
      end else if (pop && !acc) begin
        cred <= cred + CRED_W'(1);
      end
    end
  end

  always_comb begin
    wr_res     = '0;
    wr_res.doa = DOA;
    wr_res.dob = DOB;
    wr_res.tag = LUT_TAG_MAX_W'(tag2);
  end

  lut_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(lut_result_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v2),
    .din   (wr_res),
    .pop   (pop),
    .dout  (head),
    .valid (out_valid)
  );

  assign out_doa         = head.doa;
  assign out_dob         = head.dob;
  assign out_tag         = head.tag[TAG_W-1:0];
  assign unused_tag_bits = ^head.tag;

endmodule

// File: tb/tb_masked_sbox_lookup_requester.sv
// Bench for masked_sbox_lookup_requester against a 2-cycle registered-read ROM.
module tb_masked_sbox_lookup_requester;
  import masked_lut_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned LAT   = LUT_RD_LAT + 1;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [LUT_ADDR_W-1:0] in_addr_a;
  logic [LUT_ADDR_W-1:0] in_addr_b;
  logic [TAG_W-1:0]      in_tag;
  logic [LUT_ADDR_W-1:0] ADDRA;
  logic [LUT_ADDR_W-1:0] ADDRB;
  logic                  EN;
  logic [LUT_DATA_W-1:0] DOA;
  logic [LUT_DATA_W-1:0] DOB;
  logic                  out_valid;
  logic                  out_ready;
  logic [LUT_DATA_W-1:0] out_doa;
  logic [LUT_DATA_W-1:0] out_dob;
  logic [TAG_W-1:0]      out_tag;

  masked_sbox_lookup_requester #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr_a(in_addr_a), .in_addr_b(in_addr_b), .in_tag(in_tag),
    .ADDRA(ADDRA), .ADDRB(ADDRB), .EN(EN), .DOA(DOA), .DOB(DOB),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_doa(out_doa), .out_dob(out_dob), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port ROM: address latch plus output register, both gated by EN.
  logic [7:0]            rom [1024];
  logic [LUT_ADDR_W-1:0] lat_a = '0;
  logic [LUT_ADDR_W-1:0] lat_b = '0;
  logic [7:0]            reg_a = '0;
  logic [7:0]            reg_b = '0;
  always @(posedge clk) begin
    if (EN) begin
      lat_a <= ADDRA;
      lat_b <= ADDRB;
    end
    if (rst) begin
      reg_a <= '0;
      reg_b <= '0;
    end else if (EN) begin
      reg_a <= rom[lat_a];
      reg_b <= rom[lat_b];
    end
  end
  assign DOA = reg_a;
  assign DOB = reg_b;

  // Reference: every accepted request is owed a result LAT cycles later, in order.
  typedef struct {
    logic [7:0]       doa;
    logic [7:0]       dob;
    logic [TAG_W-1:0] tag;
    int unsigned      due;
  } exp_t;

  exp_t        q[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  bit          prev_acc = 1'b0;
  bit          inv_on = 1'b0;

  function automatic bit exp_ready();
    return !rst && (q.size() < DEPTH);
  endfunction

  function automatic bit exp_valid();
    return (q.size() > 0) && (q[0].due <= cyc);
  endfunction

  task automatic tick();
    exp_t e;
    bit   a;
    bit   p;
    a = in_valid && in_ready;
    p = out_valid && out_ready;
    if (rst) begin
      q.delete();
      prev_acc = 1'b0;
    end else begin
      if (p && q.size() > 0) void'(q.pop_front());
      if (a) begin
        e.doa = rom[in_addr_a];
        e.dob = rom[in_addr_b];
        e.tag = in_tag;
        e.due = cyc + LAT;
        q.push_back(e);
      end
      prev_acc = a;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_req();
    in_addr_a = LUT_ADDR_W'($urandom);
    in_addr_b = LUT_ADDR_W'($urandom);
    in_tag    = TAG_W'($urandom);
  endtask

  always @(negedge clk) begin
    if (inv_on && !rst) begin
      total++;
      assert (int'(dut.cred) + int'(dut.v1) + int'(dut.v2) + int'(dut.u_fifo.count) == int'(DEPTH))
      else begin
        bad++;
        $display("FAIL invariant cyc=%0d cred=%0d v1=%0d v2=%0d count=%0d want sum %0d",
                 cyc, dut.cred, dut.v1, dut.v2, dut.u_fifo.count, DEPTH);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; rand_req();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got %b want 0", in_ready); end
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++;
    if (EN !== 1'b0) begin bad++; $display("FAIL reset_en got %b want 0", EN); end
    total++;
    if (int'(dut.cred) != int'(DEPTH)) begin bad++; $display("FAIL reset_cred got %0d want %0d", dut.cred, DEPTH); end
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1;
    in_addr_a = 10'h001; in_addr_b = 10'h3FF; in_tag = 4'd5;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || EN !== 1'b1) begin bad++; $display("FAIL single_t ready=%b en=%b want 1 1", in_ready, EN); end
    tick();
    in_valid = 1'b0; rand_req();
    @(negedge clk);
    total++;
    if (EN !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL single_t1 en=%b ov=%b want 1 0", EN, out_valid); end
    tick();
    @(negedge clk);
    total++;
    if (EN !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_t2 en=%b ov=%b want 0 0", EN, out_valid); end
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL single_t3_valid got %b want 1", out_valid); end
    total++;
    if (out_doa !== rom[10'h001] || out_dob !== rom[10'h3FF] || out_tag !== 4'd5) begin
      bad++;
      $display("FAIL single_data got %h %h %h want %h %h 5", out_doa, out_dob, out_tag, rom[10'h001], rom[10'h3FF]);
    end
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t4_valid got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 64 + int'(LAT); i++) begin
      in_valid = (i < 64);
      rand_req();
      @(negedge clk);
      if (in_valid) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got %b want 1", i, in_ready); end
      end
      total++;
      if (out_valid !== exp_valid()) begin bad++; $display("FAIL b2b_valid i=%0d got %b want %b", i, out_valid, exp_valid()); end
      if (out_valid && q.size() > 0) begin
        got++;
        total++;
        if (out_doa !== q[0].doa || out_dob !== q[0].dob || out_tag !== q[0].tag) begin
          bad++;
          $display("FAIL b2b_data i=%0d got %h %h %h want %h %h %h", i, out_doa, out_dob, out_tag, q[0].doa, q[0].dob, q[0].tag);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (got != 64) begin bad++; $display("FAIL b2b_count got %0d want 64", got); end
  endtask

  task automatic test_backpressure();
    int unsigned accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; rand_req();
      @(negedge clk);
      total++;
      if (in_ready !== exp_ready()) begin bad++; $display("FAIL bp_ready i=%0d got %b want %b", i, in_ready, exp_ready()); end
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    total++;
    if (accepted != DEPTH) begin bad++; $display("FAIL bp_accepted got %0d want %0d", accepted, DEPTH); end
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_full ready=%b ov=%b want 0 1", in_ready, out_valid); end
    total++;
    if (int'(dut.u_fifo.count) != int'(DEPTH)) begin bad++; $display("FAIL bp_count got %0d want %0d", dut.u_fifo.count, DEPTH); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 2) begin
        total++;
        if (in_ready !== (i == 1)) begin bad++; $display("FAIL bp_ready_return i=%0d got %b want %b", i, in_ready, (i == 1)); end
      end
      total++;
      if (out_valid !== exp_valid()) begin bad++; $display("FAIL bp_drain_valid i=%0d got %b want %b", i, out_valid, exp_valid()); end
      if (out_valid && q.size() > 0) begin
        total++;
        if (out_doa !== q[0].doa || out_dob !== q[0].dob || out_tag !== q[0].tag) begin
          bad++;
          $display("FAIL bp_drain_data i=%0d got %h %h %h want %h %h %h", i, out_doa, out_dob, out_tag, q[0].doa, q[0].dob, q[0].tag);
        end
      end
      tick();
    end
  endtask

  task automatic test_credit_full();
    out_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH) + int'(LAT); i++) begin
      in_valid = (i < int'(DEPTH)); rand_req();
      @(negedge clk);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (dut.cred != '0) begin bad++; $display("FAIL cf_cred_zero got %0d want 0", dut.cred); end
    out_ready = 1'b1;
    tick();
    // accept and pop together from cred=1
    in_valid = 1'b1; rand_req();
    @(negedge clk);
    total++;
    if (int'(dut.cred) != 1 || in_ready !== 1'b1) begin bad++; $display("FAIL cf_cred_one cred=%0d ready=%b want 1 1", dut.cred, in_ready); end
    total++;
    if (out_valid && q.size() > 0 && out_tag !== q[0].tag) begin bad++; $display("FAIL cf_head_tag got %h want %h", out_tag, q[0].tag); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (int'(dut.cred) != 1) begin bad++; $display("FAIL cf_cred_hold got %0d want 1", dut.cred); end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== exp_valid()) begin bad++; $display("FAIL cf_drain_valid i=%0d got %b want %b", i, out_valid, exp_valid()); end
      if (out_valid && q.size() > 0) begin
        total++;
        if (out_doa !== q[0].doa || out_dob !== q[0].dob || out_tag !== q[0].tag) begin
          bad++;
          $display("FAIL cf_drain_data i=%0d got %h %h %h want %h %h %h", i, out_doa, out_dob, out_tag, q[0].doa, q[0].dob, q[0].tag);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; rand_req();
      @(negedge clk);
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (int'(dut.cred) != int'(DEPTH) || in_ready !== 1'b1) begin bad++; $display("FAIL rm_cred cred=%0d ready=%b want %0d 1", dut.cred, in_ready, DEPTH); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_stale i=%0d out_valid got %b want 0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_random();
    bit exp_en;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 70);
      rand_req();
      @(negedge clk);
      exp_en = (in_valid && exp_ready()) || prev_acc;
      total++;
      if (in_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready i=%0d got %b want %b", i, in_ready, exp_ready()); end
      total++;
      if (EN !== exp_en) begin bad++; $display("FAIL rnd_en i=%0d got %b want %b", i, EN, exp_en); end
      total++;
      if (out_valid !== exp_valid()) begin bad++; $display("FAIL rnd_valid i=%0d got %b want %b", i, out_valid, exp_valid()); end
      if (out_valid && q.size() > 0) begin
        total++;
        if (out_doa !== q[0].doa || out_dob !== q[0].dob || out_tag !== q[0].tag) begin
          bad++;
          $display("FAIL rnd_data i=%0d got %h %h %h want %h %h %h", i, out_doa, out_dob, out_tag, q[0].doa, q[0].dob, q[0].tag);
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== exp_valid()) begin bad++; $display("FAIL rnd_drain_valid i=%0d got %b want %b", i, out_valid, exp_valid()); end
      if (out_valid && q.size() > 0) begin
        total++;
        if (out_doa !== q[0].doa || out_dob !== q[0].dob || out_tag !== q[0].tag) begin
          bad++;
          $display("FAIL rnd_drain_data i=%0d got %h %h %h want %h %h %h", i, out_doa, out_dob, out_tag, q[0].doa, q[0].dob, q[0].tag);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_addr_a = '0; in_addr_b = '0; in_tag = '0;
    #1;
    test_reset();
    inv_on = 1'b1;
    test_single();
    test_back_to_back();
    test_backpressure();
    test_credit_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
